// File: rtl/sr_flop_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sr_flop_bank : bank of debounced, clocked SR bits with conflict policy   |
// | Optional macro SR_CONFLICT_FLAG_EN adds sticky per-channel S=R=1 flags.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sr_flop_bank #(
  parameter int CHANNELS      = 4,
  parameter int FILTER_CYCLES = 2,
  parameter int CONFLICT_MODE = 0,
  parameter bit INIT_VALUE    = 1'b0
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic [CHANNELS-1:0] S,
  input  logic [CHANNELS-1:0] R,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] Qbar,
  output logic [CHANNELS-1:0] changed
`ifdef SR_CONFLICT_FLAG_EN
  ,
  output logic [CHANNELS-1:0] conflict,
  input  logic                clrConflict
`endif
);

  localparam int                 c_CNT_W  = $clog2(FILTER_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_FILTER = c_CNT_W'(FILTER_CYCLES);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  logic [CHANNELS-1:0] r_q;
  logic [CHANNELS-1:0] r_changed;
  logic [CHANNELS-1:0] w_q_next;
`ifdef SR_CONFLICT_FLAG_EN
  logic [CHANNELS-1:0] w_fire_11;
  logic [CHANNELS-1:0] r_conflict;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]         w_cmd;
    logic [1:0]         r_prev;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_fire;
    logic               w_q_nx;

    assign w_cmd     = {S[i], R[i]};
    assign w_cnt_inc = r_cnt + c_ONE;

    // A run of identical nonzero commands fires once, on its FILTER_CYCLES-th cycle.
    always_comb begin
      w_cnt_next = r_cnt;
      w_fire     = 1'b0;
      if (w_cmd == 2'b00) begin
        w_cnt_next = '0;
      end else if (w_cmd != r_prev) begin
        w_cnt_next = c_ONE;
        w_fire     = (c_FILTER == c_ONE);
      end else if (r_cnt < c_FILTER) begin
        w_cnt_next = w_cnt_inc;
        w_fire     = (w_cnt_inc == c_FILTER);
      end
    end

    always_comb begin
      w_q_nx = r_q[i];
      if (w_fire) begin
        case (w_cmd)
          2'b10: w_q_nx = 1'b1;
          2'b01: w_q_nx = 1'b0;
          2'b11: begin
            case (CONFLICT_MODE)
              1:       w_q_nx = 1'b1;
              2:       w_q_nx = 1'b0;
              3:       w_q_nx = ~r_q[i];
              default: w_q_nx = r_q[i];
            endcase
          end
          default: w_q_nx = r_q[i];
        endcase
      end
    end

    assign w_q_next[i] = w_q_nx;
`ifdef SR_CONFLICT_FLAG_EN
    assign w_fire_11[i] = w_fire & (w_cmd == 2'b11);
`endif

    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        r_prev <= 2'b00;
        r_cnt  <= '0;
      end else begin
        r_prev <= w_cmd;
        r_cnt  <= w_cnt_next;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_q       <= {CHANNELS{INIT_VALUE}};
      r_changed <= '0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
    end
  end

`ifdef SR_CONFLICT_FLAG_EN
  // A new conflict on the clearing edge survives the clear.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_conflict <= '0;
    end else begin
      r_conflict <= (r_conflict & ~{CHANNELS{clrConflict}}) | w_fire_11;
    end
  end

  assign conflict = r_conflict;
`endif

  assign Q       = r_q;
  assign Qbar    = ~r_q;
  assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_sr_flop_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sr_flop_bank : directed self-checking bench for sr_flop_bank          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sr_flop_bank;

  logic clock;
  logic resetN;
  int   n_vec;
  int   n_bad;

  logic [3:0] s_a, r_a, s_f3, r_f3, s_m, r_m, s_f2, r_f2;
  logic [3:0] q_a, qb_a, ch_a, q_f3, qb_f3, ch_f3, q_f2, qb_f2, ch_f2;
  logic [3:0] q_m0, qb_m0, ch_m0, q_m1, qb_m1, ch_m1;
  logic [3:0] q_m2, qb_m2, ch_m2, q_m3, qb_m3, ch_m3;
`ifdef SR_CONFLICT_FLAG_EN
  logic       clr;
  logic [3:0] cf_a, cf_f3, cf_m0, cf_m1, cf_m2, cf_m3, cf_f2;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  sr_flop_bank #(.CHANNELS(4), .FILTER_CYCLES(2), .CONFLICT_MODE(0), .INIT_VALUE(1'b1)) u_a (
    .clock(clock), .resetN(resetN), .S(s_a), .R(r_a), .Q(q_a), .Qbar(qb_a),
`ifdef SR_CONFLICT_FLAG_EN
    .conflict(cf_a), .clrConflict(clr),
`endif
    .changed(ch_a));

  sr_flop_bank #(.CHANNELS(4), .FILTER_CYCLES(3), .CONFLICT_MODE(0), .INIT_VALUE(1'b0)) u_f3 (
    .clock(clock), .resetN(resetN), .S(s_f3), .R(r_f3), .Q(q_f3), .Qbar(qb_f3),
`ifdef SR_CONFLICT_FLAG_EN
    .conflict(cf_f3), .clrConflict(clr),
`endif
    .changed(ch_f3));

  sr_flop_bank #(.CHANNELS(4), .FILTER_CYCLES(1), .CONFLICT_MODE(0), .INIT_VALUE(1'b0)) u_m0 (
    .clock(clock), .resetN(resetN), .S(s_m), .R(r_m), .Q(q_m0), .Qbar(qb_m0),
`ifdef SR_CONFLICT_FLAG_EN
    .conflict(cf_m0), .clrConflict(clr),
`endif
    .changed(ch_m0));

  sr_flop_bank #(.CHANNELS(4), .FILTER_CYCLES(1), .CONFLICT_MODE(1), .INIT_VALUE(1'b0)) u_m1 (
    .clock(clock), .resetN(resetN), .S(s_m), .R(r_m), .Q(q_m1), .Qbar(qb_m1),
`ifdef SR_CONFLICT_FLAG_EN
    .conflict(cf_m1), .clrConflict(clr),
`endif
    .changed(ch_m1));

  sr_flop_bank #(.CHANNELS(4), .FILTER_CYCLES(1), .CONFLICT_MODE(2), .INIT_VALUE(1'b0)) u_m2 (
    .clock(clock), .resetN(resetN), .S(s_m), .R(r_m), .Q(q_m2), .Qbar(qb_m2),
`ifdef SR_CONFLICT_FLAG_EN
    .conflict(cf_m2), .clrConflict(clr),
`endif
    .changed(ch_m2));

  sr_flop_bank #(.CHANNELS(4), .FILTER_CYCLES(1), .CONFLICT_MODE(3), .INIT_VALUE(1'b0)) u_m3 (
    .clock(clock), .resetN(resetN), .S(s_m), .R(r_m), .Q(q_m3), .Qbar(qb_m3),
`ifdef SR_CONFLICT_FLAG_EN
    .conflict(cf_m3), .clrConflict(clr),
`endif
    .changed(ch_m3));

  sr_flop_bank #(.CHANNELS(4), .FILTER_CYCLES(2), .CONFLICT_MODE(3), .INIT_VALUE(1'b0)) u_f2 (
    .clock(clock), .resetN(resetN), .S(s_f2), .R(r_f2), .Q(q_f2), .Qbar(qb_f2),
`ifdef SR_CONFLICT_FLAG_EN
    .conflict(cf_f2), .clrConflict(clr),
`endif
    .changed(ch_f2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    n_vec = 0;
    n_bad = 0;
    resetN = 1'b0;
    {s_a, r_a, s_f3, r_f3, s_m, r_m, s_f2, r_f2} = '0;
`ifdef SR_CONFLICT_FLAG_EN
    clr = 1'b0;
`endif

    // Reset values
    step(); step();
    check("rst_q",    q_a,  4'hF);
    check("rst_qbar", qb_a, 4'h0);
    check("rst_chg",  ch_a, 4'h0);
    check("rst_q_f3", q_f3, 4'h0);

    // Clear all of u_a (filter 2), then async reset mid-cycle
    resetN = 1'b1;
    r_a = 4'hF;
    step();
    check("a_r_partial", q_a, 4'hF);
    step();
    check("a_r_fire_q",   q_a,  4'h0);
    check("a_r_fire_chg", ch_a, 4'hF);
    check("a_r_fire_qb",  qb_a, 4'hF);
    r_a = 4'h0;
    step();
    check("a_chg_pulse_end", ch_a, 4'h0);
    #3 resetN = 1'b0;
    #1;
    check("async_rst_q",   q_a,  4'hF);
    check("async_rst_qb",  qb_a, 4'h0);
    check("async_rst_chg", ch_a, 4'h0);
    step();
    resetN = 1'b1;

    // Filter 3: two-cycle run must not fire
    s_f3 = 4'h1; step(); step();
    s_f3 = 4'h0; step();
    check("f3_short_q",   q_f3,  4'h0);
    check("f3_short_chg", ch_f3, 4'h0);
    s_f3 = 4'h1; step(); step();
    check("f3_partial_q", q_f3, 4'h0);
    step();
    check("f3_fire_q",   q_f3,  4'h1);
    check("f3_fire_chg", ch_f3, 4'h1);
    step();
    check("f3_held_q",   q_f3,  4'h1);
    check("f3_held_chg", ch_f3, 4'h0);
    s_f3 = 4'h0;
    step();

    // Reset mid-count on u_f3 (Q back to 0) aborts the partial run
    s_f3 = 4'h1; step(); step();
    #3 resetN = 1'b0;
    step();
    resetN = 1'b1;
    step();
    check("rst_abort_q1", q_f3, 4'h0);
    step();
    check("rst_abort_q2", q_f3, 4'h0);
    step();
    check("rst_abort_fire", q_f3, 4'h1);
    s_f3 = 4'h0;
    step();

    // Conflict modes, filter 1, single S=R=1 on ch0
    s_m = 4'h1; r_m = 4'h1;
    step();
    check("m0_q",   q_m0,  4'h0);
    check("m0_chg", ch_m0, 4'h0);
    check("m1_q",   q_m1,  4'h1);
    check("m1_chg", ch_m1, 4'h1);
    check("m2_q",   q_m2,  4'h0);
    check("m3_q",   q_m3,  4'h1);
    s_m = 4'h0; r_m = 4'h0;
    step();
    s_m = 4'h1; r_m = 4'h1;
    step();
    check("m3_toggle_back", q_m3,  4'h0);
    check("m3_toggle_chg",  ch_m3, 4'h1);
    check("m1_reset_chg",   ch_m1, 4'h0);
    s_m = 4'h0; r_m = 4'h0;
    step();

    // Held 11 on ch1 in toggle mode fires exactly once
    s_m = 4'h2; r_m = 4'h2;
    step();
    check("held_first_q",   q_m3,  4'h2);
    check("held_first_chg", ch_m3, 4'h2);
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      pulses += int'(ch_m3[1]);
    end
    check("held_q",      q_m3, 4'h2);
    check("held_pulses", pulses, 0);
    s_m = 4'h0; r_m = 4'h0;
    step();

    // Independence and restart: start from Q=4'b1100
    s_f2 = 4'hC; step(); step();
    check("f2_init_q", q_f2, 4'hC);
    s_f2 = 4'h0; step();
    s_f2 = 4'h4; r_f2 = 4'h8; step();
    check("f2_e1_q", q_f2, 4'hC);
    s_f2 = 4'h4; r_f2 = 4'hC; step();
    check("f2_e2_q",   q_f2,  4'h4);
    check("f2_e2_chg", ch_f2, 4'h8);
    s_f2 = 4'h4; r_f2 = 4'h4; step();
    check("f2_e3_q",   q_f2,  4'h0);
    check("f2_e3_chg", ch_f2, 4'h4);
    s_f2 = 4'h0; r_f2 = 4'h0; step();

    // A one-cycle 00 gap breaks the run
    s_f2 = 4'h1; step();
    s_f2 = 4'h0; step();
    s_f2 = 4'h1; step();
    check("f2_gap_q", q_f2, 4'h0);
    step();
    check("f2_gap_refire", q_f2, 4'h1);
    s_f2 = 4'h0; step();

`ifdef SR_CONFLICT_FLAG_EN
    // u_m1 carries conflicts on ch0/ch1 from earlier; clear first
    clr = 1'b1; step(); clr = 1'b0;
    check("cf_clear_init", cf_m1, 4'h0);
    s_m = 4'h1; r_m = 4'h1; step();
    check("cf_set", cf_m1, 4'h1);
    s_m = 4'h0; r_m = 4'h0; step();
    check("cf_sticky", cf_m1, 4'h1);
    check("cf_filter_quiet", cf_f3, 4'h0);
    s_m = 4'h1; r_m = 4'h1; clr = 1'b1; step();
    check("cf_set_wins", cf_m1, 4'h1);
    s_m = 4'h0; r_m = 4'h0; step();
    clr = 1'b0;
    check("cf_clr_alone", cf_m1, 4'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Clocked, parametrised successor to the single SR latch cell: a bank of CHANNELS independent SR storage bits.
- Each channel has a per-channel input qualification filter (consecutive-cycle debounce), a selectable S=R=1 conflict policy, and a one-cycle change pulse.
- Guaranteed complementary outputs; Q and Qbar are never equal.
- Sits between raw control/strobe inputs and downstream logic that needs glitch-free, registered set/reset state.

Parameters:
- CHANNELS, 4, number of independent SR channels (1..32).
- FILTER_CYCLES, 2, consecutive identical nonzero command cycles required before the command takes effect (1..255).
- CONFLICT_MODE, 0, S=R=1 policy: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
- INIT_VALUE, 0, reset value of every Q bit (0 or 1).

Ports:
- clock  input  1  rising-edge clock.
- resetN  input  1  asynchronous, active-low reset.
- S  input  CHANNELS  per-channel set request; synchronous to clock.
- R  input  CHANNELS  per-channel reset request; synchronous to clock.
- Q  output  CHANNELS  stored state, registered.
- Qbar  output  CHANNELS  always the bitwise inverse of Q.
- changed  output  CHANNELS  one-cycle pulse, high in the cycle after Q[i] changed value.

Behaviour:
- One clock; reset is asynchronous and active-low (resetN).
- While resetN=0: Q=all INIT_VALUE, Qbar=~Q, changed=0, all counters=0, all stored previous commands=00.
- Release of resetN takes effect at the next rising edge.
- Per channel i, cmd={S[i],R[i]}. Each channel holds prev_cmd (2b) and cnt (width clog2(FILTER_CYCLES+1)). Each rising edge:
  - cmd=00 -> cnt<=0, no action.
  - cmd!=prev_cmd (nonzero) -> cnt<=1; fire if FILTER_CYCLES==1.
  - cmd==prev_cmd, cnt<FILTER_CYCLES -> cnt<=cnt+1; fire when cnt+1==FILTER_CYCLES.
  - cmd==prev_cmd, cnt==FILTER_CYCLES -> saturate, no action. A held command fires exactly once.
  - prev_cmd<=cmd every edge.
- Fire action, applied at the same edge:
  - 10 -> Q<=1.
  - 01 -> Q<=0.
  - 11 -> hold / Q<=1 / Q<=0 / Q<=~Q for CONFLICT_MODE 0/1/2/3.
- Latency: Q updates at the edge sampling the FILTER_CYCLES-th consecutive identical cycle. For FILTER_CYCLES=1, Q updates at the first sampling edge.
- Qbar is combinationally ~Q.
- changed[i]<=(Q_next[i]!=Q[i]) at the same edge, so it is high for exactly one cycle, aligned with the new Q. Firing a set on an already-set bit gives changed=0.
- Command switches mid-count (e.g. 10 -> 11) restart the count at 1; partial counts never fire.
- A 00 gap of one cycle breaks the run.
- Channels are fully independent; simultaneous fires on several channels all apply in the same edge.
- Reset asserted mid-count aborts all counts; no fire is retained after reset.

Optional Feature:
- Macro SR_CONFLICT_FLAG_EN.
- When defined, adds two ports:
  - conflict (output, CHANNELS): sticky bit, set at any edge where channel i fires with cmd=11; cleared to 0 by reset.
  - clrConflict (input, 1): synchronous clear of all conflict bits. If a set and a clear coincide on the same edge, the set wins.
- When undefined: no conflict or clrConflict ports and no flag registers; all other behaviour is identical.

Test Plan:
- Reset: CHANNELS=4, INIT_VALUE=1, hold resetN=0 -> Q=4'hF, Qbar=4'h0, changed=0. Assert resetN asynchronously mid-cycle -> outputs return to reset values immediately.
- Filter: FILTER_CYCLES=3, S[0]=1 for 2 cycles then 0 -> Q[0] unchanged. S[0]=1 for 3 cycles -> Q[0]=1 after the 3rd edge, changed[0]=1 for exactly that one cycle.
- Held command: FILTER_CYCLES=1, CONFLICT_MODE=3, S[1]=R[1]=1 held 10 cycles from Q[1]=0 -> Q[1]=1 after the first edge, then stays 1. changed[1] pulses once.
- Conflict modes: FILTER_CYCLES=1, Q=0, S=R=1 for one cycle:
  - mode 0 -> Q=0, changed=0.
  - mode 1 -> Q=1.
  - mode 2 -> Q=0.
  - mode 3 -> Q=1, and a second separate pulse -> Q=0.
- Independence and restart: FILTER_CYCLES=2, ch2 10,11,11 and ch3 01,01 in the same cycles from Q=4'b1100:
  - ch3 clears at the 2nd edge.
  - ch2 applies its conflict policy only at the 3rd edge (10 -> 11 restarts the count).
- SR_CONFLICT_FLAG_EN: a qualifying 11 on ch0 -> conflict[0]=1 sticky. clrConflict coinciding with a new qualifying 11 -> conflict stays 1. clrConflict alone -> 0.
